// File: rtl/memory_access.sv
// memory_access: memory stage of the five-stage MIPS pipeline, doubling as the
// memory/writeback pipeline register.
//
// Byte, halfword and word loads/stores run over a req/ack data-memory bus
// (big-endian, offset 00 = bits 31:24). While an access is outstanding the
// stage raises stall_req and feeds bubbles to writeback. The result is
// registered on the ack edge. Non-memory ops pass straight through in one cycle.
//
// Optional feature (compile-time macro MEM_ALIGN_CHECK_EN):
//   defined   - misaligned LH/LHU/SH/LW/SW issue no request. They produce a
//               one-cycle bubble carrying exc_adel/exc_ades and badvaddr.
//   undefined - exception outputs are tied to 0. Halfword accesses ignore
//               mem_addr[0], and word accesses ignore mem_addr[1:0].
//
// Ports:
//   clk, rst (async, active-low)
//   from execute/memory : dest_addr, write_or_not, wdata, aluop, mem_addr,
//                         regOp2, HILO_enabler, HILO_HI, HILO_LO
//   stall_req           : combinational hold for upstream stages
//   data-memory bus     : dmem_req/we/addr/sel/wdata out; dmem_rdata/ack in
//   to writeback        : *_output registers
//   exceptions          : exc_adel, exc_ades, badvaddr (registered)
//
// State  | meaning
// IDLE   | no access outstanding; non-memory ops pass through
// BUSY   | request on the bus, waiting for dmem_ack
module memory_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  dest_addr,
  input  logic        write_or_not,
  input  logic [31:0] wdata,
  input  logic [7:0]  aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] regOp2,
  input  logic        HILO_enabler,
  input  logic [31:0] HILO_HI,
  input  logic [31:0] HILO_LO,
  output logic        stall_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_sel,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [4:0]  dest_addr_output,
  output logic        write_or_not_output,
  output logic [31:0] wdata_output,
  output logic        HILO_enabler_output,
  output logic [31:0] HILO_HI_output,
  output logic [31:0] HILO_LO_output,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] badvaddr
);

  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2B;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_sel_q, dmem_sel_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [4:0]  dest_q, dest_d;
  logic        wen_q, wen_d;
  logic [31:0] res_q, res_d;
  logic        hilo_en_q, hilo_en_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operation decode
  logic is_load, is_store, is_mem, is_byte, is_half, mem_go;
  assign is_load  = aluop inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign is_store = aluop inside {OP_SB, OP_SH, OP_SW};
  assign is_mem   = is_load | is_store;
  assign is_byte  = aluop inside {OP_LB, OP_LBU, OP_SB};
  assign is_half  = aluop inside {OP_LH, OP_LHU, OP_SH};

`ifdef MEM_ALIGN_CHECK_EN
  logic is_word, misalign;
  assign is_word  = aluop inside {OP_LW, OP_SW};
  assign misalign = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
  assign mem_go   = is_mem & ~misalign;
`else
  assign mem_go   = is_mem;
`endif

  // Byte enables and store-lane replication
  logic [3:0]  sel_c;
  logic [31:0] store_c;
  always_comb begin
    sel_c   = 4'b1111;
    store_c = regOp2;
    if (is_byte) begin
      sel_c   = 4'b1000 >> mem_addr[1:0];
      store_c = {4{regOp2[7:0]}};
    end else if (is_half) begin
      sel_c   = mem_addr[1] ? 4'b0011 : 4'b1100;
      store_c = {2{regOp2[15:0]}};
    end
  end

  // Load lane extraction; inputs are held stable while BUSY, so the live
  // aluop/mem_addr still describe the outstanding access on the ack cycle.
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;
  always_comb begin
    case (mem_addr[1:0])
      2'b00:   byte_c = dmem_rdata[31:24];
      2'b01:   byte_c = dmem_rdata[23:16];
      2'b10:   byte_c = dmem_rdata[15:8];
      default: byte_c = dmem_rdata[7:0];
    endcase
    half_c = mem_addr[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    case (aluop)
      OP_LB:   load_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  load_c = {24'd0, byte_c};
      OP_LH:   load_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  load_c = {16'd0, half_c};
      default: load_c = dmem_rdata;
    endcase
  end

  // Next-state and output logic
  logic bubble;
  always_comb begin
    state_d      = state_q;
    stall_req    = 1'b0;
    bubble       = 1'b0;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_sel_d   = dmem_sel_q;
    dmem_wdata_d = dmem_wdata_q;
    dest_d       = dest_addr;
    wen_d        = write_or_not;
    res_d        = wdata;
    hilo_en_d    = HILO_enabler;
    hi_d         = HILO_HI;
    lo_d         = HILO_LO;
    case (state_q)
      IDLE: begin
        // Misaligned ops (when checked) still bubble but never reach the bus.
        if (is_mem) bubble = 1'b1;
        if (mem_go) begin
          stall_req    = 1'b1;
          state_d      = BUSY;
          dmem_req_d   = 1'b1;
          dmem_we_d    = is_store;
          dmem_addr_d  = {mem_addr[31:2], 2'b00};
          dmem_sel_d   = sel_c;
          dmem_wdata_d = store_c;
        end
      end
      BUSY: begin
        if (!dmem_ack) begin
          stall_req = 1'b1;
          bubble    = 1'b1;
        end else begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          if (is_load) res_d = load_c;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bubble) begin
      dest_d    = 5'd0;
      wen_d     = 1'b0;
      res_d     = 32'd0;
      hilo_en_d = 1'b0;
      hi_d      = 32'd0;
      lo_d      = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_sel_q   <= 4'd0;
      dmem_wdata_q <= 32'd0;
      dest_q       <= 5'd0;
      wen_q        <= 1'b0;
      res_q        <= 32'd0;
      hilo_en_q    <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_sel_q   <= dmem_sel_d;
      dmem_wdata_q <= dmem_wdata_d;
      dest_q       <= dest_d;
      wen_q        <= wen_d;
      res_q        <= res_d;
      hilo_en_q    <= hilo_en_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic        adel_q, adel_d, ades_q, ades_d;
  logic [31:0] bad_q, bad_d;
  always_comb begin
    adel_d = 1'b0;
    ades_d = 1'b0;
    bad_d  = 32'd0;
    if (state_q == IDLE && misalign) begin
      adel_d = is_load;
      ades_d = is_store;
      bad_d  = mem_addr;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adel_q <= 1'b0;
      ades_q <= 1'b0;
      bad_q  <= 32'd0;
    end else begin
      adel_q <= adel_d;
      ades_q <= ades_d;
      bad_q  <= bad_d;
    end
  end
  assign exc_adel = adel_q;
  assign exc_ades = ades_q;
  assign badvaddr = bad_q;
`else
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
  assign badvaddr = 32'd0;
`endif

  assign dmem_req            = dmem_req_q;
  assign dmem_we             = dmem_we_q;
  assign dmem_addr           = dmem_addr_q;
  assign dmem_sel            = dmem_sel_q;
  assign dmem_wdata          = dmem_wdata_q;
  assign dest_addr_output    = dest_q;
  assign write_or_not_output = wen_q;
  assign wdata_output        = res_q;
  assign HILO_enabler_output = hilo_en_q;
  assign HILO_HI_output      = hi_q;
  assign HILO_LO_output      = lo_q;

endmodule

// File: tb/tb_memory_access.sv
// Randomised scoreboard bench for memory_access. The driver issues instructions
// and plays the data memory. Expected writeback results and bus requests are
// queued. A monitor on the falling edge pops and compares them whenever the DUT
// presents a result, exception or new request. Every other cycle must be an
// all-zero bubble.
module tb_memory_access;

  localparam logic [7:0] LB = 8'h20, LH = 8'h21, LW = 8'h23, LBU = 8'h24,
                         LHU = 8'h25, SB = 8'h28, SH = 8'h29, SW = 8'h2B;

  logic        clk = 1'b0, rst = 1'b0;
  logic [4:0]  dest_addr = '0;
  logic        write_or_not = 1'b0;
  logic [31:0] wdata = '0, mem_addr = '0, regOp2 = '0, HILO_HI = '0, HILO_LO = '0;
  logic [7:0]  aluop = '0;
  logic        HILO_enabler = 1'b0;
  logic        stall_req, dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_sel;
  logic [4:0]  dest_addr_output;
  logic        write_or_not_output, HILO_enabler_output, exc_adel, exc_ades;
  logic [31:0] wdata_output, HILO_HI_output, HILO_LO_output, badvaddr;

  memory_access dut (
    .clk(clk), .rst(rst), .dest_addr(dest_addr), .write_or_not(write_or_not),
    .wdata(wdata), .aluop(aluop), .mem_addr(mem_addr), .regOp2(regOp2),
    .HILO_enabler(HILO_enabler), .HILO_HI(HILO_HI), .HILO_LO(HILO_LO),
    .stall_req(stall_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_sel(dmem_sel), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dest_addr_output(dest_addr_output), .write_or_not_output(write_or_not_output),
    .wdata_output(wdata_output), .HILO_enabler_output(HILO_enabler_output),
    .HILO_HI_output(HILO_HI_output), .HILO_LO_output(HILO_LO_output),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        hen;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        adel;
    logic        ades;
    logic [31:0] bad;
  } res_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  res_t rq[$];
  bus_t bq[$];
  int   checks = 0, errors = 0;
  logic bus_seen = 1'b0;

  // Reference model: access size, lane offset and data from the ISA rules
  function automatic int op_size(input logic [7:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic bit misaligned(input logic [7:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    int sz = op_size(op);
    return sz > 1 && (int'(addr % 4) % sz) != 0;
`else
    return (op == 8'hFF) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int lane_off(input logic [7:0] op, input logic [31:0] addr);
    int sz = op_size(op);
    return (int'(addr % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] load_val(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int sz = op_size(op);
    int off = lane_off(op, addr);
    longint unsigned mask = (64'd1 << (8 * sz)) - 64'd1;
    longint unsigned v = ({32'd0, rd} >> (8 * (4 - off - sz))) & mask;
    if ((op == LB || op == LH) && v[8 * sz - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic bus_t bus_val(input logic [7:0] op, input logic [31:0] addr,
                                   input logic [31:0] d);
    bus_t b;
    int sz = op_size(op);
    int off = lane_off(op, addr);
    logic [31:0] m = 32'(((1 << sz) - 1) << (4 - off - sz));
    b.we    = !op_load(op);
    b.addr  = addr - (addr % 4);
    b.sel   = m[3:0];
    b.wdata = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    res_t got, e;
    bus_t gb, eb;
    if (!dmem_req) bus_seen = 1'b0;
    if (rst) begin
      if (dmem_req && !bus_seen) begin
        bus_seen = 1'b1;
        checks++;
        gb = {dmem_we, dmem_addr, dmem_sel, dmem_wdata};
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: got %h expected no request", gb);
        end else begin
          eb = bq.pop_front();
          if (!eb.we) begin gb.wdata = '0; eb.wdata = '0; end
          if (gb !== eb) begin
            errors++;
            $display("FAIL bus_request: got %h expected %h at %0t", gb, eb, $time);
          end
        end
      end
      got = {write_or_not_output, dest_addr_output, wdata_output, HILO_enabler_output,
             HILO_HI_output, HILO_LO_output, exc_adel, exc_ades, badvaddr};
      checks++;
      if (write_or_not_output || exc_adel || exc_ades) begin
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got %h expected bubble", got);
        end else begin
          e = rq.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL result: got %h expected %h at %0t", got, e, $time);
          end
        end
      end else if (got !== '0) begin
        errors++;
        $display("FAIL bubble: got %h expected 0 at %0t", got, $time);
      end
    end
  end

  // Drive one instruction; for an accepted memory op, ack after `delay` busy cycles
  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] op2,
                       input logic [31:0] rd, input int delay);
    res_t e;
    int   sz = op_size(op);
    bit   mis = misaligned(op, addr);
    @(negedge clk);
    aluop = op; mem_addr = addr; regOp2 = op2; dmem_rdata = rd;
    dest_addr = 5'($urandom); write_or_not = 1'b1; wdata = $urandom;
    HILO_enabler = 1'($urandom); HILO_HI = $urandom; HILO_LO = $urandom;
    dmem_ack = 1'($urandom);
    e = '0;
    if (sz != 0 && mis) begin
      e.adel = op_load(op);
      e.ades = !op_load(op);
      e.bad  = addr;
    end else begin
      e.wen = 1'b1; e.dest = dest_addr; e.hen = HILO_enabler; e.hi = HILO_HI; e.lo = HILO_LO;
      e.data = (sz != 0 && op_load(op)) ? load_val(op, addr, rd) : wdata;
      if (sz != 0) bq.push_back(bus_val(op, addr, op2));
    end
    rq.push_back(e);
    #1 chk("stall_issue", 32'(stall_req), 32'(sz != 0 && !mis));
    if (sz != 0 && !mis) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk); dmem_ack = 1'b0;
        #1 chk("stall_wait", 32'(stall_req), 32'd1);
      end
      @(negedge clk); dmem_ack = 1'b1;
      #1 chk("stall_ack", 32'(stall_req), 32'd0);
    end
  endtask

  task automatic zero_inputs();
    aluop = '0; mem_addr = '0; regOp2 = '0; dest_addr = '0; write_or_not = 1'b0;
    wdata = '0; HILO_enabler = 1'b0; HILO_HI = '0; HILO_LO = '0;
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    aluop = LW; mem_addr = 32'h200; write_or_not = 1'b1; dmem_ack = 1'b0;
    bq.push_back(bus_val(LW, 32'h200, regOp2));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_req_drop", 32'(dmem_req), 32'd0);
    chk("rst_wen", 32'(write_or_not_output), 32'd0);
    rq.delete(); bq.delete();
    zero_inputs();
    dmem_ack = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); dmem_ack = 1'b0;
    #1 chk("late_ack_ignored", 32'(dmem_req), 32'd0);
  endtask

  logic [7:0] mem_ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    logic [7:0]  op;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    #1 chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wdata_out", wdata_output, 32'd0);
    chk("rst_wen", 32'(write_or_not_output), 32'd0);
    chk("rst_sel", 32'(dmem_sel), 32'd0);
    @(negedge clk); rst = 1'b1;

    issue(LW,  32'h100, 32'h0,        32'hDEADBEEF, 0);
    issue(LB,  32'h103, 32'h0,        32'h000000F0, 1);
    issue(LBU, 32'h103, 32'h0,        32'h000000F0, 0);
    issue(SH,  32'h102, 32'h1234ABCD, 32'h0,        2);
    issue(LW,  32'h104, 32'h0,        32'hCAFEF00D, 3);
    issue(8'h00, 32'h0, 32'h0,        32'h0,        0);
    issue(LHU, 32'h100, 32'h0,        32'h8001_7FFF, 0);
    issue(LH,  32'h102, 32'h0,        32'h8001_8002, 1);
    reset_mid_access();
    issue(LW,  32'h300, 32'h0,        32'h1357_9BDF, 1);
`ifdef MEM_ALIGN_CHECK_EN
    issue(LW,  32'h102, 32'h0, 32'h0, 0);
    issue(SH,  32'h101, 32'h0, 32'h0, 0);
    issue(LHU, 32'h103, 32'h0, 32'h0, 0);
    issue(SW,  32'h10A, 32'h0, 32'h0, 0);
`endif
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do op = 8'($urandom); while (op_size(op) != 0);
      end else begin
        op = mem_ops[$urandom_range(0, 7)];
      end
      a = $urandom;
      issue(op, a, $urandom, $urandom, $urandom_range(0, 3));
    end
    @(negedge clk); zero_inputs();
    repeat (3) @(negedge clk);
    #1 chk("results_drained", 32'(rq.size()), 32'd0);
    chk("requests_drained", 32'(bq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
